// File: rtl/bank_ram_phy_if.sv
// bank_ram_phy_if: command, write-data and read-return bus of the banked SRAM.
// BANK_RAM_PHY_PARITY_EN adds the per-bank rerr return.
interface bank_ram_phy_if #(
  parameter int NUM_BANKS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) ();
  logic                            cmd_valid;
  logic                            cmd_rw;
  logic [NUM_BANKS-1:0]            cmd_mask;
  logic [ADDR_WIDTH-1:0]           cmd_addr;
  logic                            cmd_ready;
  logic                            wvalid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata;
  logic                            wready;
  logic                            rvalid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;
  logic                            init_done;
  logic                            drop_err;
`ifdef BANK_RAM_PHY_PARITY_EN
  logic [NUM_BANKS-1:0]            rerr;
`endif

  modport master (
`ifdef BANK_RAM_PHY_PARITY_EN
    input  rerr,
`endif
    output cmd_valid, cmd_rw, cmd_mask, cmd_addr,
    output wvalid, wdata,
    input  cmd_ready, wready, rvalid, rdata,
    input  init_done, drop_err
  );

  modport slave (
`ifdef BANK_RAM_PHY_PARITY_EN
    output rerr,
`endif
    input  cmd_valid, cmd_rw, cmd_mask, cmd_addr,
    input  wvalid, wdata,
    output cmd_ready, wready, rvalid, rdata,
    output init_done, drop_err
  );
endinterface

// File: rtl/bank_ram_phy.sv
// bank_ram_phy: NUM_BANKS masked SRAM banks on one address, zero-filled after reset.
// Optional per-word even parity with rerr when BANK_RAM_PHY_PARITY_EN is defined.
module bank_ram_phy #(
  parameter int NUM_BANKS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  bank_ram_phy_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BW    = NUM_BANKS * DATA_WIDTH;
`ifdef BANK_RAM_PHY_PARITY_EN
  localparam int MW    = DATA_WIDTH + 1;
`else
  localparam int MW    = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [MW-1:0]         mem [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0]  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [BW-1:0]         wd;
  logic                  rfire;
  logic                  wfire;
  logic                  ready;
  logic                  done;
  logic                  drop_q;
  logic [RD_LATENCY-1:0] v_q;
  logic [BW-1:0]         d_q [RD_LATENCY];
`ifdef BANK_RAM_PHY_PARITY_EN
  logic [NUM_BANKS-1:0]  e_q [RD_LATENCY];
`endif

  function automatic logic [MW-1:0] enc(input logic [DATA_WIDTH-1:0] d);
`ifdef BANK_RAM_PHY_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Sweep counter walks every address once during zero-fill
  always_ff @(posedge clk) begin
    if (rst)                   cnt_q <= '0;
    else if (state_q == S_INIT) cnt_q <= cnt_q + 1'b1;
  end

  // Leave INIT after the last word has been cleared
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && cnt_q == LAST) state_d = S_RUN;
  end

  // Handshake outputs and RAM write-port controls
  always_comb begin
    we    = '0;
    waddr = cnt_q;
    wd    = '0;
    rfire = 1'b0;
    wfire = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_INIT: we = '1;
      S_RUN: begin
        done  = 1'b1;
        ready = !bus.cmd_rw || bus.wvalid;
        wfire = bus.cmd_valid && bus.cmd_rw && bus.wvalid;
        rfire = bus.cmd_valid && !bus.cmd_rw && !rst;
        waddr = bus.cmd_addr;
        wd    = bus.wdata;
        if (wfire && !rst) we = bus.cmd_mask;
      end
      default: ;
    endcase
  end

  // Sticky flag for commands dropped while zero-filling
  always_ff @(posedge clk) begin
    if (rst)                                    drop_q <= 1'b0;
    else if (state_q == S_INIT && bus.cmd_valid) drop_q <= 1'b1;
  end

  // Bank write port, one enable per bank
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (we[b]) mem[b][waddr] <= enc(wd[b*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Read pipeline; masked-out and idle stages carry zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        d_q[i] <= '0;
`ifdef BANK_RAM_PHY_PARITY_EN
        e_q[i] <= '0;
`endif
      end
    end else begin
      v_q[0] <= rfire;
      for (int b = 0; b < NUM_BANKS; b++) begin
        d_q[0][b*DATA_WIDTH +: DATA_WIDTH] <=
          (rfire && bus.cmd_mask[b]) ?
          mem[b][bus.cmd_addr][DATA_WIDTH-1:0] : '0;
`ifdef BANK_RAM_PHY_PARITY_EN
        e_q[0][b] <= rfire && bus.cmd_mask[b] &&
                     (^mem[b][bus.cmd_addr]);
`endif
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
`ifdef BANK_RAM_PHY_PARITY_EN
        e_q[i] <= e_q[i-1];
`endif
      end
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.wready    = wfire;
  assign bus.rvalid    = v_q[RD_LATENCY-1];
  assign bus.rdata     = d_q[RD_LATENCY-1];
  assign bus.init_done = done;
  assign bus.drop_err  = drop_q;
`ifdef BANK_RAM_PHY_PARITY_EN
  assign bus.rerr      = e_q[RD_LATENCY-1];
`endif
endmodule

// File: tb/tb_bank_ram_phy.sv
// tb_bank_ram_phy: random and directed traffic against an array model,
// read returns checked by a queue-based monitor.
module tb_bank_ram_phy;
  localparam int NB    = 5;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = NB * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bank_ram_phy_if #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  bank_ram_phy #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [BW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] mm [NB][DEPTH];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_rd(input logic [AW-1:0] a,
                                             input logic [NB-1:0] m);
    logic [BW-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++)
      if (m[b]) r[b*DW +: DW] = mm[b][a];
    return r;
  endfunction

  task automatic model_zero();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mm[b][a] = '0;
  endtask

  // Monitor: every rvalid pops one expectation; idle cycles must show zero
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rvalid_unexpected: got rvalid=1 required 0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("rdata", bus.rdata, mon_e.data);
          chk("rd_latency", BW'(cyc - mon_e.cyc), BW'(LAT));
`ifdef BANK_RAM_PHY_PARITY_EN
          chk("rerr", BW'(bus.rerr), '0);
`endif
        end
      end else begin
        chk("idle_rdata", bus.rdata, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.wvalid    = 1'b0;
    bus.cmd_mask  = '0;
    bus.cmd_addr  = '0;
    bus.wdata     = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] m,
                    input logic [BW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.wvalid    = 1'b1;
    bus.cmd_mask  = m;
    bus.cmd_addr  = a;
    bus.wdata     = d;
    @(negedge clk);
    chk("wr_cmd_ready", BW'(bus.cmd_ready), 1);
    chk("wr_wready", BW'(bus.wready), 1);
    for (int b = 0; b < NB; b++)
      if (m[b]) mm[b][a] = d[b*DW +: DW];
    step();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [NB-1:0] m);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.wvalid    = 1'b0;
    bus.cmd_mask  = m;
    bus.cmd_addr  = a;
    exp_q.push_back('{data: model_rd(a, m), cyc: cyc});
    @(negedge clk);
    chk("rd_cmd_ready", BW'(bus.cmd_ready), 1);
    step();
  endtask

  task automatic stall_wr(input logic [AW-1:0] a, input logic [NB-1:0] m,
                          input logic [BW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_rw    = 1'b1;
      bus.wvalid    = 1'b0;
      bus.cmd_mask  = m;
      bus.cmd_addr  = a;
      bus.wdata     = ~d;
      @(negedge clk);
      chk("stall_cmd_ready", BW'(bus.cmd_ready), 0);
      chk("stall_wready", BW'(bus.wready), 0);
      step();
    end
    wr(a, m, d);
  endtask

  task automatic init_wait(input bit inject);
    int n;
    n = 0;
    while (n < 600) begin
      step();
      n++;
      if (inject && n == 10) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = 1'b1;
        bus.wvalid    = 1'b1;
        bus.cmd_mask  = '1;
        bus.cmd_addr  = 9'h003;
        bus.wdata     = {NB{32'hDEADBEEF}};
      end else begin
        idle();
      end
      @(negedge clk);
      if (inject && n == 10) begin
        chk("init_cmd_ready", BW'(bus.cmd_ready), 0);
        chk("init_wready", BW'(bus.wready), 0);
      end
      if (bus.init_done === 1'b1) break;
    end
    chk("init_len", BW'(n), BW'(DEPTH));
    step();
  endtask

  function automatic logic [BW-1:0] rnd_data();
    logic [BW-1:0] d;
    for (int b = 0; b < NB; b++) d[b*DW +: DW] = $urandom();
    return d;
  endfunction

  initial begin
    logic [BW-1:0] d;
    int            w;
    idle();
    rst = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_init_done", BW'(bus.init_done), 0);
    chk("rst_cmd_ready", BW'(bus.cmd_ready), 0);
    chk("rst_wready", BW'(bus.wready), 0);
    chk("rst_rvalid", BW'(bus.rvalid), 0);
    chk("rst_drop_err", BW'(bus.drop_err), 0);
    step();
    model_zero();
    rst = 1'b0;

    init_wait(1'b1);
    chk("drop_err_set", BW'(bus.drop_err), 1);

    rd(9'h1FF, 5'b11111);
    rd(9'h003, 5'b11111);

    d = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2,
         32'hA1A1A1A1, 32'hA0A0A0A0};
    wr(9'h012, 5'b10101, d);
    rd(9'h012, 5'b11111);

    for (int i = 0; i < 4; i++) wr(AW'(i), 5'b11111, rnd_data());
    for (int i = 0; i < 4; i++) rd(AW'(i), 5'b11111);

    wr(9'h005, 5'b00000, rnd_data());
    rd(9'h005, 5'b00000);
    rd(9'h005, 5'b11111);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: wr(AW'($urandom_range(0, 15)), NB'($urandom()), rnd_data());
        1: rd(AW'($urandom_range(0, 15)), NB'($urandom()));
        2: stall_wr(AW'($urandom_range(0, 15)), NB'($urandom()),
                    rnd_data(), $urandom_range(1, 2));
        default: begin
          idle();
          step();
        end
      endcase
    end
    idle();
    repeat (LAT + 2) step();
    @(negedge clk);
    chk("drop_err_sticky", BW'(bus.drop_err), 1);
    step();

    wr(9'h020, 5'b11111, rnd_data());
    rd(9'h020, 5'b11111);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_mask  = '1;
    bus.cmd_addr  = 9'h020;
    rst = 1'b1;
    exp_q.delete();
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("midrst_init_done", BW'(bus.init_done), 0);
    step();
    model_zero();
    rst = 1'b0;
    init_wait(1'b0);
    chk("drop_err_cleared", BW'(bus.drop_err), 0);
    rd(9'h020, 5'b11111);

    stall_wr(9'h040, 5'b11111, rnd_data(), 3);
    rd(9'h040, 5'b11111);
    idle();
    @(negedge clk);
    chk("stall_drop_err", BW'(bus.drop_err), 0);
    step();

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      step();
      w++;
    end
    chk("drain", BW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
